// File: rtl/pic_pkg.sv
// Shared definitions for the PIC IRR/ISR/priority-resolver slice.
// Holds the OCW2 command codes, the default lowest-priority pointer and a
// level-to-one-hot helper used by the resolver.
package pic_pkg;

  // Reset value of the lowest-priority pointer (7 makes IR0 the highest priority)
  localparam logic [2:0] LP_RST_DEF     = 3'd7;

  // OCW2 {R,SL,EOI} encodings that carry an action; all others are no-ops
  localparam logic [2:0] OCW2_NSEOI     = 3'b001;
  localparam logic [2:0] OCW2_SEOI      = 3'b011;
  localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI  = 3'b111;

  // Convert a 3-bit IR level into a one-hot 8-bit mask
  function automatic logic [7:0] lvl_onehot(input logic [2:0] lvl);
    lvl_onehot = 8'd1 << lvl;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating priority encoder: returns the first set bit of req scanning
// upward from lp+1 with wraparound (lp is the lowest-priority level).
// Purely combinational; valid is low when req is all zero (lvl then 0).
module pic_prio_enc #(
  parameter int NIRQ = 8,
  parameter int LW   = $clog2(NIRQ)
) (
  input  logic [NIRQ-1:0] req,
  input  logic [LW-1:0]   lp,
  output logic            valid,
  output logic [LW-1:0]   lvl
);

  // Scan from the lowest priority back to the highest so the last hit
  // (closest to lp+1) is the one that sticks.
  always_comb begin
    logic [LW-1:0] idx;
    valid = |req;
    lvl   = '0;
    idx   = '0;
    for (int i = NIRQ; i >= 1; i--) begin
      idx = LW'((int'(lp) + i) % NIRQ);
      if (req[idx]) lvl = idx;
    end
  end

endmodule

// File: rtl/pic_irq_resolver.sv
// IRR/ISR/priority-resolver stage of an 8259-style PIC (fully nested mode).
// int_req is registered (one cycle after IRR changes); vec_lvl/spurious valid the cycle after inta1.
// Optional macro PIC_AUTO_ROTATE_EN enables OCW2 rotation / set-priority; otherwise fixed priority.
module pic_irq_resolver
  import pic_pkg::*;
#(
  parameter int         NIRQ   = 8,
  parameter logic [2:0] LP_RST = LP_RST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] ir,
  input  logic            ltim,
  input  logic [NIRQ-1:0] imr,
  input  logic            aeoi,
  input  logic            inta1,
  input  logic            inta2,
  input  logic            eoi_stb,
  input  logic [2:0]      eoi_rse,
  input  logic [2:0]      eoi_lvl,
  output logic            int_req,
  output logic [2:0]      vec_lvl,
  output logic            spurious,
  output logic [NIRQ-1:0] irr,
  output logic [NIRQ-1:0] isr
);

  logic [NIRQ-1:0] ir_q;
  logic [2:0]      lp;

  logic [NIRQ-1:0] req;
  logic            w_vld;
  logic [2:0]      w_lvl;
  logic            h_vld;
  logic [2:0]      h_lvl;
  logic [2:0]      w_rank;
  logic [2:0]      h_rank;
  logic            int_req_nxt;

  logic [NIRQ-1:0] eoi_clr;
  logic [NIRQ-1:0] inta_set;
  logic [NIRQ-1:0] isr_nxt;
  logic [NIRQ-1:0] irr_nxt;

`ifdef PIC_AUTO_ROTATE_EN
  logic            lp_wr;
  logic [2:0]      lp_nxt;
`else
  assign lp = LP_RST;
`endif

  // In level mode a line that has already dropped cannot be granted
  assign req = irr & ~imr & (ltim ? ir : {NIRQ{1'b1}});

  pic_prio_enc #(.NIRQ(NIRQ)) u_req_enc (
    .req   (req),
    .lp    (lp),
    .valid (w_vld),
    .lvl   (w_lvl)
  );

  pic_prio_enc #(.NIRQ(NIRQ)) u_isr_enc (
    .req   (isr),
    .lp    (lp),
    .valid (h_vld),
    .lvl   (h_lvl)
  );

  // Rank 0 is the highest priority (the level just above lp)
  assign w_rank      = w_lvl - lp - 3'd1;
  assign h_rank      = h_lvl - lp - 3'd1;
  assign int_req_nxt = w_vld && (!h_vld || (w_rank < h_rank));

  // Decode OCW2 and auto-EOI into ISR clear bits and pointer updates
  always_comb begin
    eoi_clr = '0;
`ifdef PIC_AUTO_ROTATE_EN
    lp_wr   = 1'b0;
    lp_nxt  = lp;
`endif
    if (eoi_stb) begin
      case (eoi_rse)
        OCW2_NSEOI: begin
          if (h_vld) eoi_clr = lvl_onehot(h_lvl);
        end
        OCW2_SEOI: begin
          if (h_vld) eoi_clr = lvl_onehot(eoi_lvl);
        end
        OCW2_ROT_NSEOI: begin
          if (h_vld) begin
            eoi_clr = lvl_onehot(h_lvl);
`ifdef PIC_AUTO_ROTATE_EN
            lp_wr   = 1'b1;
            lp_nxt  = h_lvl;
`endif
          end
        end
        OCW2_ROT_SEOI: begin
          if (h_vld) begin
            eoi_clr = lvl_onehot(eoi_lvl);
`ifdef PIC_AUTO_ROTATE_EN
            lp_wr   = 1'b1;
            lp_nxt  = eoi_lvl;
`endif
          end
        end
`ifdef PIC_AUTO_ROTATE_EN
        OCW2_SET_PRIO: begin
          lp_wr  = 1'b1;
          lp_nxt = eoi_lvl;
        end
`endif
        default: ;
      endcase
    end
    // Auto-EOI retires the vectored level; nothing to retire after a spurious cycle or an empty ISR
    if (inta2 && aeoi && h_vld && !spurious) begin
      eoi_clr = eoi_clr | lvl_onehot(vec_lvl);
    end
  end

  // Next ISR/IRR: an inta1 grant sets ISR after clears, so set wins on the same bit
  always_comb begin
    inta_set = (inta1 && w_vld) ? lvl_onehot(w_lvl) : '0;
    isr_nxt  = (isr & ~eoi_clr) | inta_set;
    if (ltim) begin
      irr_nxt = ir;
    end else begin
      irr_nxt = ((irr | (ir & ~ir_q)) & ir) & ~inta_set;
    end
  end

  // Request/service registers and the inta1 vector capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= '0;
      irr      <= '0;
      isr      <= '0;
      int_req  <= 1'b0;
      vec_lvl  <= 3'd0;
      spurious <= 1'b0;
    end else begin
      ir_q    <= ir;
      irr     <= irr_nxt;
      isr     <= isr_nxt;
      int_req <= inta1 ? 1'b0 : int_req_nxt;
      if (inta1) begin
        if (w_vld) begin
          vec_lvl  <= w_lvl;
          spurious <= 1'b0;
        end else begin
          vec_lvl  <= 3'd7;
          spurious <= 1'b1;
        end
      end
    end
  end

`ifdef PIC_AUTO_ROTATE_EN
  // Lowest-priority pointer, moved by rotate and set-priority commands
  always_ff @(posedge clk) begin
    if (rst) begin
      lp <= LP_RST;
    end else if (lp_wr) begin
      lp <= lp_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pic_irq_resolver.sv
// Directed bench for pic_irq_resolver with a queue-based scoreboard.
// Stimulus pushes expected snapshots and raises smp; the monitor pops on smp at negedge.
// Expected values follow the rotate macro when PIC_AUTO_ROTATE_EN is defined.
module tb_pic_irq_resolver;

  localparam logic [4:0] M_IRR = 5'b00001;
  localparam logic [4:0] M_ISR = 5'b00010;
  localparam logic [4:0] M_INT = 5'b00100;
  localparam logic [4:0] M_VEC = 5'b01000;
  localparam logic [4:0] M_SPR = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       int_req;
    logic [2:0] vec;
    logic       spr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ir = '0;
  logic       ltim = 1'b0;
  logic [7:0] imr = '0;
  logic       aeoi = 1'b0;
  logic       inta1 = 1'b0;
  logic       inta2 = 1'b0;
  logic       eoi_stb = 1'b0;
  logic [2:0] eoi_rse = '0;
  logic [2:0] eoi_lvl = '0;
  logic       int_req;
  logic [2:0] vec_lvl;
  logic       spurious;
  logic [7:0] irr;
  logic [7:0] isr;

  exp_t exp_q[$];
  logic smp = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef PIC_AUTO_ROTATE_EN
  localparam logic [2:0] W_ROT   = 3'd4;
  localparam logic [7:0] ISR_ROT = 8'h10;
  localparam logic [7:0] IRR_ROT = 8'h04;
  localparam logic [2:0] W_CO    = 3'd2;
`else
  localparam logic [2:0] W_ROT   = 3'd2;
  localparam logic [7:0] ISR_ROT = 8'h04;
  localparam logic [7:0] IRR_ROT = 8'h10;
  localparam logic [2:0] W_CO    = 3'd4;
`endif

  pic_irq_resolver dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .ltim     (ltim),
    .imr      (imr),
    .aeoi     (aeoi),
    .inta1    (inta1),
    .inta2    (inta2),
    .eoi_stb  (eoi_stb),
    .eoi_rse  (eoi_rse),
    .eoi_lvl  (eoi_lvl),
    .int_req  (int_req),
    .vec_lvl  (vec_lvl),
    .spurious (spurious),
    .irr      (irr),
    .isr      (isr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] mask, input logic [7:0] irr_e,
                     input logic [7:0] isr_e, input logic int_e, input logic [2:0] vec_e,
                     input logic spr_e);
    exp_t e;
    e.name = name; e.mask = mask; e.irr = irr_e; e.isr = isr_e;
    e.int_req = int_e; e.vec = vec_e; e.spr = spr_e;
    exp_q.push_back(e);
    smp = 1'b1;
    step();
    smp = 1'b0;
  endtask

  task automatic pulse_inta1();
    inta1 = 1'b1; step(); inta1 = 1'b0;
  endtask

  task automatic pulse_inta2();
    inta2 = 1'b1; step(); inta2 = 1'b0;
  endtask

  task automatic ocw2(input logic [2:0] rse, input logic [2:0] lvl);
    eoi_stb = 1'b1; eoi_rse = rse; eoi_lvl = lvl;
    step();
    eoi_stb = 1'b0;
  endtask

  // Monitor: pop one expected snapshot per sample strobe and compare selected fields
  always @(negedge clk) begin
    if (smp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.mask[0]) begin
          checks++;
          if (irr !== e.irr) begin errors++; $display("FAIL %s.irr got %h want %h", e.name, irr, e.irr); end
        end
        if (e.mask[1]) begin
          checks++;
          if (isr !== e.isr) begin errors++; $display("FAIL %s.isr got %h want %h", e.name, isr, e.isr); end
        end
        if (e.mask[2]) begin
          checks++;
          if (int_req !== e.int_req) begin errors++; $display("FAIL %s.int_req got %b want %b", e.name, int_req, e.int_req); end
        end
        if (e.mask[3]) begin
          checks++;
          if (vec_lvl !== e.vec) begin errors++; $display("FAIL %s.vec_lvl got %0d want %0d", e.name, vec_lvl, e.vec); end
        end
        if (e.mask[4]) begin
          checks++;
          if (spurious !== e.spr) begin errors++; $display("FAIL %s.spurious got %b want %b", e.name, spurious, e.spr); end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset", M_ALL, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Edge on IR2: latched next cycle, int_req one cycle later, then granted
    ir = 8'h04;
    step();
    chk("edge_latch", M_IRR | M_INT, 8'h04, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("int_req_up", M_IRR | M_INT, 8'h04, 8'h00, 1'b1, 3'd0, 1'b0);
    pulse_inta1();
    chk("grant_ir2", M_ALL, 8'h00, 8'h04, 1'b0, 3'd2, 1'b0);

    // Lower-priority IR5 is held off while IR2 is in service
    ir = 8'h24;
    step(); step();
    chk("nested_low", M_IRR | M_ISR | M_INT, 8'h20, 8'h04, 1'b0, 3'd0, 1'b0);

    // Higher-priority IR0 interrupts IR2
    ir = 8'h25;
    step(); step();
    chk("nested_high", M_IRR | M_INT, 8'h21, 8'h00, 1'b1, 3'd0, 1'b0);
    pulse_inta1();
    chk("nested_grant", M_ALL, 8'h20, 8'h05, 1'b0, 3'd0, 1'b0);

    // Two non-specific EOIs retire IR0 then IR2
    ocw2(3'b001, 3'd0);
    chk("nseoi_first", M_ISR, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0);
    ocw2(3'b001, 3'd0);
    ir = 8'h00;
    step();
    chk("nseoi_clean", M_IRR | M_ISR, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Level mode: IR3 pulse dropped before inta1 -> spurious
    ltim = 1'b1;
    ir = 8'h08;
    step();
    chk("level_follow", M_IRR, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0);
    ir = 8'h00;
    step(); step();
    pulse_inta1();
    chk("spurious", M_ALL, 8'h00, 8'h00, 1'b0, 3'd7, 1'b1);
    ltim = 1'b0;
    step();

    // Auto-EOI on IR6
    aeoi = 1'b1;
    ir = 8'h40;
    step(); step();
    chk("aeoi_req", M_IRR | M_INT, 8'h40, 8'h00, 1'b1, 3'd0, 1'b0);
    pulse_inta1();
    chk("aeoi_grant", M_ALL, 8'h00, 8'h40, 1'b0, 3'd6, 1'b0);
    pulse_inta2();
    chk("aeoi_clear", M_ISR | M_INT | M_SPR, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    aeoi = 1'b0;
    ir = 8'h00;
    step();

    // IR3 in service, then rotate on non-specific EOI
    ir = 8'h08;
    step(); step();
    pulse_inta1();
    chk("ir3_grant", M_ISR | M_VEC, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0);
    ir = 8'h00;
    ocw2(3'b101, 3'd0);
    chk("rot_nseoi", M_ISR, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // IR2 and IR4 together: winner depends on whether the pointer rotated
    ir = 8'h14;
    step(); step();
    chk("two_req", M_IRR | M_INT, 8'h14, 8'h00, 1'b1, 3'd0, 1'b0);
    pulse_inta1();
    chk("rot_winner", M_ALL, IRR_ROT, ISR_ROT, 1'b0, W_ROT, 1'b0);

    // Specific EOI coincident with inta1 on the granted level: set wins
    eoi_stb = 1'b1; eoi_rse = 3'b011; eoi_lvl = W_CO;
    inta1 = 1'b1;
    step();
    inta1 = 1'b0; eoi_stb = 1'b0;
    chk("eoi_vs_inta1", M_IRR | M_ISR | M_VEC | M_SPR, 8'h00, 8'h14, 1'b0, W_CO, 1'b0);

    // Reset between inta1 and inta2, then an orphan inta2 with auto-EOI
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset", M_ALL, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    ir = 8'h00;
    aeoi = 1'b1;
    pulse_inta2();
    chk("orphan_inta2", M_ISR | M_VEC | M_SPR, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    aeoi = 1'b0;

    step(); step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
